spi_mstr_gen: RTL and testbench

Parametrised, next-generation SPI master for the follower's serial peripherals (A2D, inertial sensor). It adds over the fixed 16-bit mode-0 master:
- configurable frame width and SCLK rate;
- all four CPOL/CPHA modes, selected per transaction;
- multiple slave selects;
- an optional double-frame transaction, in which the result is taken from the second frame.

It sits between the sensor-control FSMs and the board SPI pins, with one engine shared by all slaves.

---
 rtl/spi_mstr_gen.sv | 200 ++++++++++++++++++++
 tb/tb_spi_mstr_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr_gen.sv
// spi_mstr_gen: parametrised SPI master supporting all four CPOL/CPHA modes,
// several slave selects and an optional back-to-back double frame.
// The pins are decoded from the state held during the previous clock, so they
// lag the state register by exactly one cycle; this places SS_n low from edge 1
// and done at edge 1+F.
module spi_mstr_gen #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned HALF_PER = 16,
  parameter  int unsigned NUM_SS   = 1,
  localparam int unsigned SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              dbl,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned CNT_W = $clog2(2 * HALF_PER);
  localparam int unsigned BIT_W = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] HP_MID   = CNT_W'(HALF_PER);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(2 * HALF_PER - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FRONT = 3'd1,
    XFER  = 3'd2,
    BACK  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   cmd_q;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [SEL_W-1:0]    ss_q;
  logic                cpol_q;
  logic                cpha_q;
  logic                dbl_q;
  logic                second_q;
  logic                fin_q;
  logic [NUM_SS-1:0]   ss_mask_c;

  // Active-low select pattern for the latched slave index; out-of-range keeps all high
  always_comb begin
    ss_mask_c = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ss_q == SEL_W'(i)) ss_mask_c[i] = 1'b0;
    end
  end

  // Transaction FSM with registered pin, status and shift-register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      cmd_q    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      ss_q     <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
      fin_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      SCLK     <= 1'b0;
      SS_n     <= '1;
      MOSI     <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state)
        IDLE: begin
          SS_n <= '1;
          MOSI <= 1'b0;
          if (fin_q) begin
            // completion cycle: a wrt arriving now is deliberately dropped
            done <= 1'b1;
            busy <= 1'b0;
            SCLK <= cpol_q;
          end else if (wrt) begin
            cmd_q    <= cmd;
            tx_sr    <= cmd;
            cpol_q   <= mode[1];
            cpha_q   <= mode[0];
            ss_q     <= ss_sel;
            dbl_q    <= dbl;
            second_q <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            // move SCLK to the new idle level while every select is still high
            SCLK     <= mode[1];
            cnt      <= '0;
            state    <= FRONT;
          end else begin
            SCLK <= cpol_q;
          end
        end

        FRONT: begin
          SS_n <= ss_mask_c;
          SCLK <= cpol_q;
          MOSI <= cpha_q ? 1'b0 : tx_sr[DATA_W-1];
          if (cnt == HP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= XFER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        XFER: begin
          SS_n <= ss_mask_c;
          if (cnt == '0) begin
            // leading edge
            SCLK <= ~cpol_q;
            if (cpha_q) begin
              MOSI  <= tx_sr[DATA_W-1];
              tx_sr <= tx_sr << 1;
            end else begin
              rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            end
          end else if (cnt == HP_MID) begin
            // trailing edge
            SCLK <= cpol_q;
            if (cpha_q) begin
              rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            end else if (bit_cnt != BIT_LAST) begin
              MOSI  <= tx_sr[DATA_W-2];
              tx_sr <= tx_sr << 1;
            end
          end
          if (cnt == PER_LAST) begin
            cnt <= '0;
            if (bit_cnt == BIT_LAST) state <= BACK;
            else bit_cnt <= bit_cnt + BIT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BACK: begin
          SS_n <= ss_mask_c;
          SCLK <= cpol_q;
          MOSI <= 1'b0;
          if (cnt == HP_LAST) begin
            rd_data <= rx_sr;
            cnt     <= '0;
            if (dbl_q && !second_q) begin
              state <= GAP;
            end else begin
              fin_q <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          SS_n <= '1;
          SCLK <= cpol_q;
          MOSI <= 1'b0;
          if (cnt == PER_LAST) begin
            tx_sr    <= cmd_q;
            second_q <= 1'b1;
            cnt      <= '0;
            state    <= FRONT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          SS_n  <= '1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mstr_gen.sv
// tb_spi_mstr_gen: directed bench for spi_mstr_gen with a default instance and a
// 24-bit / 4-slave instance sharing one stimulus path and one slave model.
module tb_spi_mstr_gen;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic        dbl;
  logic        loop;
  logic        dut_sel;
  logic [23:0] cmd;
  logic [1:0]  mode;
  logic [1:0]  ss_sel;

  logic        busy_a, done_a, sclk_a, mosi_a, miso_a, ss_a;
  logic [15:0] rd_a;
  logic        busy_b, done_b, sclk_b, mosi_b, miso_b;
  logic [23:0] rd_b;
  logic [3:0]  ss_b;

  logic        obs_busy, obs_done, obs_sclk, obs_mosi, ss_all_hi;
  logic [23:0] obs_rd;
  logic [3:0]  obs_ss;

  // slave model state (written only by the slave process)
  logic        slv_miso = 1'b0;
  logic [23:0] slv_sr   = '0;
  logic [23:0] mosi_cap = '0;
  int          lead_cnt = 0;
  int          ss_falls = 0;
  logic        ss_prev  = 1'b1;
  logic        sclk_prev = 1'b0;

  // slave model configuration (written only by the stimulus process)
  logic        slv_cpol, slv_cpha;
  logic [23:0] slv_w0, slv_w1;
  int          fall_base;

  // per-transaction observations
  int          done_edge, ss_first, ss_rise, gap_hi, lead_base;
  logic        busy_e1, busy_pre;
  logic [3:0]  ss_seen;
  logic [23:0] rd_mid;

  int n_checks = 0;
  int n_errors = 0;

  spi_mstr_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .wrt(wrt & ~dut_sel), .cmd(cmd[15:0]), .mode(mode),
    .ss_sel(ss_sel[0]), .dbl(dbl), .busy(busy_a), .done(done_a), .rd_data(rd_a),
    .SCLK(sclk_a), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_mstr_gen #(.DATA_W(24), .HALF_PER(4), .NUM_SS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wrt(wrt & dut_sel), .cmd(cmd), .mode(mode),
    .ss_sel(ss_sel), .dbl(dbl), .busy(busy_b), .done(done_b), .rd_data(rd_b),
    .SCLK(sclk_b), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b)
  );

  assign miso_a    = loop ? mosi_a : slv_miso;
  assign miso_b    = loop ? mosi_b : slv_miso;
  assign obs_busy  = dut_sel ? busy_b : busy_a;
  assign obs_done  = dut_sel ? done_b : done_a;
  assign obs_sclk  = dut_sel ? sclk_b : sclk_a;
  assign obs_mosi  = dut_sel ? mosi_b : mosi_a;
  assign obs_rd    = dut_sel ? rd_b : {8'h00, rd_a};
  assign obs_ss    = dut_sel ? ss_b : {3'b111, ss_a};
  assign ss_all_hi = &obs_ss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI slave: loads a left-aligned word on select fall, shifts per CPHA, captures MOSI
  always @(obs_sclk or ss_all_hi) begin
    if (ss_prev === 1'b1 && ss_all_hi === 1'b0) begin
      slv_sr = (ss_falls == fall_base) ? slv_w0 : slv_w1;
      ss_falls++;
      if (!slv_cpha) begin
        slv_miso = slv_sr[23];
        slv_sr   = slv_sr << 1;
      end
    end else if (ss_all_hi === 1'b0 && obs_sclk !== sclk_prev) begin
      if (obs_sclk !== slv_cpol) begin
        lead_cnt++;
        if (slv_cpha) begin
          slv_miso = slv_sr[23];
          slv_sr   = slv_sr << 1;
        end else begin
          mosi_cap = {mosi_cap[22:0], obs_mosi};
        end
      end else begin
        if (slv_cpha) begin
          mosi_cap = {mosi_cap[22:0], obs_mosi};
        end else begin
          slv_miso = slv_sr[23];
          slv_sr   = slv_sr << 1;
        end
      end
    end
    ss_prev   = ss_all_hi;
    sclk_prev = obs_sclk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction: wrt sampled at edge 0, then watch edges 1.. until done or a bound
  task automatic run_txn(input logic sel, input logic [23:0] c, input logic [1:0] m,
                         input logic [1:0] s, input logic d, input logic lp,
                         input int repulse, input int rst_at);
    logic prev_hi;
    @(negedge clk);
    dut_sel = sel; cmd = c; mode = m; ss_sel = s; dbl = d; loop = lp;
    slv_cpol = m[1]; slv_cpha = m[0];
    fall_base = ss_falls; lead_base = lead_cnt;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    done_edge = -1; ss_first = -1; ss_rise = -1; gap_hi = 0; ss_seen = '0;
    busy_e1 = 1'b0; busy_pre = 1'b0; rd_mid = '0; prev_hi = 1'b1;
    for (int k = 1; k <= 1300; k++) begin
      @(posedge clk); #1;
      if (k == rst_at) break;
      if (k == 1) busy_e1 = obs_busy;
      if (k == 600) rd_mid = obs_rd;
      if (obs_ss != 4'hF) begin
        ss_seen |= ~obs_ss;
        if (ss_first < 0) ss_first = k;
        prev_hi = 1'b0;
      end else begin
        if (!prev_hi) ss_rise = k;
        if (ss_first >= 0 && !obs_done) gap_hi++;
        prev_hi = 1'b1;
      end
      if (k == repulse - 1) begin wrt = 1'b1; cmd = 24'hFFFFFF; end
      if (k == repulse) wrt = 1'b0;
      if (obs_done) begin done_edge = k; break; end
      busy_pre = obs_busy;
    end
  endtask

  initial begin
    rst_n = 1'b0; wrt = 1'b0; dbl = 1'b0; loop = 1'b1; dut_sel = 1'b0;
    cmd = '0; mode = '0; ss_sel = '0;
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_w0 = '0; slv_w1 = '0; fall_base = 0;
    #12;
    check_val("rst_ss_a", 32'(obs_ss), 32'hF);
    check_val("rst_ss_b", 32'(ss_b), 32'hF);
    check_val("rst_sclk", 32'(sclk_a), 32'h0);
    check_val("rst_mosi", 32'(mosi_a), 32'h0);
    check_val("rst_busy", 32'(busy_a), 32'h0);
    check_val("rst_done", 32'(done_a), 32'h0);
    check_val("rst_rd", 32'(rd_a), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, loopback
    run_txn(1'b0, 24'h00A5C3, 2'b00, 2'd0, 1'b0, 1'b1, 0, 0);
    check_val("m0_busy_e1", 32'(busy_e1), 32'h1);
    check_val("m0_ss_first", 32'(ss_first), 32'd1);
    check_val("m0_ss_rise", 32'(ss_rise), 32'd545);
    check_val("m0_done_edge", 32'(done_edge), 32'd545);
    check_val("m0_busy_pre", 32'(busy_pre), 32'h1);
    check_val("m0_busy_end", 32'(obs_busy), 32'h0);
    check_val("m0_rd", 32'(obs_rd), 32'h00A5C3);
    check_val("m0_leads", 32'(lead_cnt - lead_base), 32'd16);
    check_val("m0_mosi_seq", 32'(mosi_cap[15:0]), 32'hA5C3);
    check_val("m0_ss_seen", 32'(ss_seen), 32'h1);

    // mode 3, slave returns 3C0F
    slv_w0 = {16'h3C0F, 8'h00}; slv_w1 = '0;
    run_txn(1'b0, 24'h009A6B, 2'b11, 2'd0, 1'b0, 1'b0, 0, 0);
    check_val("m3_done_edge", 32'(done_edge), 32'd545);
    check_val("m3_rd", 32'(obs_rd), 32'h003C0F);
    check_val("m3_mosi_seq", 32'(mosi_cap[15:0]), 32'h9A6B);
    check_val("m3_leads", 32'(lead_cnt - lead_base), 32'd16);
    check_val("m3_sclk_idle", 32'(obs_sclk), 32'h1);

    // double frame, mode 0, slave returns 1111 then 2BCD
    slv_w0 = {16'h1111, 8'h00}; slv_w1 = {16'h2BCD, 8'h00};
    run_txn(1'b0, 24'h005555, 2'b00, 2'd0, 1'b1, 1'b0, 0, 0);
    check_val("dbl_done_edge", 32'(done_edge), 32'd1121);
    check_val("dbl_gap", 32'(gap_hi), 32'd32);
    check_val("dbl_rd_mid", 32'(rd_mid), 32'h001111);
    check_val("dbl_rd", 32'(obs_rd), 32'h002BCD);
    check_val("dbl_leads", 32'(lead_cnt - lead_base), 32'd32);
    check_val("dbl_ss_rise", 32'(ss_rise), 32'd1121);
    check_val("dbl_sclk_idle", 32'(obs_sclk), 32'h0);

    // 24-bit, 4 slaves, ss_sel=2, loopback; wrt on the done-rising edge is dropped
    run_txn(1'b1, 24'hC0FFEE, 2'b00, 2'd2, 1'b0, 1'b1, 201, 0);
    check_val("b_done_edge", 32'(done_edge), 32'd201);
    check_val("b_ss_seen", 32'(ss_seen), 32'h4);
    check_val("b_leads", 32'(lead_cnt - lead_base), 32'd24);
    check_val("b_rd", 32'(obs_rd), 32'hC0FFEE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("b_wrt_at_done_busy", 32'(obs_busy), 32'h0);
    check_val("b_wrt_at_done_done", 32'(obs_done), 32'h1);

    // wrt re-pulsed while busy is ignored
    run_txn(1'b0, 24'h000001, 2'b00, 2'd0, 1'b0, 1'b1, 100, 0);
    check_val("rep_done_edge", 32'(done_edge), 32'd545);
    check_val("rep_rd", 32'(obs_rd), 32'h000001);

    // out-of-range select: full timing, no select asserted
    run_txn(1'b0, 24'h001234, 2'b01, 2'd1, 1'b0, 1'b1, 0, 0);
    check_val("oor_done_edge", 32'(done_edge), 32'd545);
    check_val("oor_ss_seen", 32'(ss_seen), 32'h0);
    check_val("oor_rd", 32'(obs_rd), 32'h001234);

    // asynchronous reset mid-transfer
    run_txn(1'b0, 24'h00BEEF, 2'b00, 2'd0, 1'b0, 1'b1, 0, 300);
    check_val("rst_mid_ss_low", 32'(obs_ss), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_ss", 32'(obs_ss), 32'hF);
    check_val("rst_mid_busy", 32'(obs_busy), 32'h0);
    check_val("rst_mid_rd", 32'(obs_rd), 32'h0);
    check_val("rst_mid_done", 32'(obs_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("post_rst_done", 32'(obs_done), 32'h0);

    // mode 2 after reset, loopback
    run_txn(1'b0, 24'h006DB7, 2'b10, 2'd0, 1'b0, 1'b1, 0, 0);
    check_val("m2_done_edge", 32'(done_edge), 32'd545);
    check_val("m2_rd", 32'(obs_rd), 32'h006DB7);
    check_val("m2_sclk_idle", 32'(obs_sclk), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
